// File: rtl/event_capture_arb_pkg.sv
// Shared constants and helpers for the event capture arbiter.
// Timestamp capture is compiled in with EVENT_CAPTURE_ARB_TIMESTAMP_EN.
package event_capture_arb_pkg;

    localparam int unsigned NUM_CH_MIN = 2;
    localparam int unsigned NUM_CH_MAX = 16;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/event_capture_arb_if.sv
// Request/payload inputs and presented-event outputs of the event capture arbiter.
interface event_capture_arb_if
    import event_capture_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TS_WIDTH   = 16
);
    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_sig;
    logic [NUM_CH-1:0]            ovf_clr;
    logic [NUM_CH-1:0]            ch_ovf;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_sig;
    logic [CH_W-1:0]              out_ch;
    logic [TS_WIDTH-1:0]          out_ts;

    modport master (
        output ch_req, ch_sig, ovf_clr, out_ready,
        input  ch_ovf, out_valid, out_sig, out_ch, out_ts
    );

    modport slave (
        input  ch_req, ch_sig, ovf_clr, out_ready,
        output ch_ovf, out_valid, out_sig, out_ch, out_ts
    );

endinterface

// File: rtl/event_capture_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; priority rotates past the
// granted channel only when the grant is accepted.
module rr_arbiter
    import event_capture_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_accept,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gnt_idx
);

    logic [CH_W-1:0] r_ptr;
    logic            w_hi_found;
    logic            w_lo_found;
    logic [CH_W-1:0] w_hi_idx;
    logic [CH_W-1:0] w_lo_idx;

    // Lowest requester at/after the pointer wins, else lowest one below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                if (CH_W'(k) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = CH_W'(k);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = CH_W'(k);
                end
            end
        end
        o_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_gnt     = '0;
        if (w_hi_found || w_lo_found) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept && (|i_req)) begin
            r_ptr <= (o_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/event_capture_arb.sv
// Captures rising-edge events per channel into slots and presents them one at a
// time through a ready/valid stage. EVENT_CAPTURE_ARB_TIMESTAMP_EN adds timestamps.
module event_capture_arb
    import event_capture_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TS_WIDTH   = 16
) (
    input logic                clk,
    input logic                rst,
    event_capture_arb_if.slave bus
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("event_capture_arb: NUM_CH out of range");
    end

    logic [NUM_CH-1:0]     r_req_prev;
    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     r_ovf;
    logic [DATA_WIDTH-1:0] r_slot [NUM_CH];
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_sig;
    logic [CH_W-1:0]       r_out_ch;

    logic [NUM_CH-1:0]     w_evt;
    logic [NUM_CH-1:0]     w_gnt;
    logic [NUM_CH-1:0]     w_gnt_take;
    logic [NUM_CH-1:0]     w_drop;
    logic [NUM_CH-1:0]     w_capture;
    logic [NUM_CH-1:0]     w_pending_d;
    logic [NUM_CH-1:0]     w_ovf_d;
    logic [CH_W-1:0]       w_gnt_idx;
    logic                  w_load;

    assign w_evt  = bus.ch_req & ~r_req_prev;
    assign w_load = (~r_out_valid | bus.out_ready) & (|r_pending);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_pending),
        .i_accept  (w_load),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // A channel being granted this cycle frees its slot, so a new event there is kept.
    always_comb begin
        w_gnt_take  = w_load ? w_gnt : '0;
        w_drop      = w_evt & r_pending & ~w_gnt_take;
        w_capture   = w_evt & ~w_drop;
        w_pending_d = (r_pending & ~w_gnt_take) | w_capture;
        w_ovf_d     = (r_ovf & ~bus.ovf_clr) | w_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_prev  <= '1;
            r_pending   <= '0;
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
            r_out_sig   <= '0;
            r_out_ch    <= '0;
        end else begin
            r_req_prev <= bus.ch_req;
            r_pending  <= w_pending_d;
            r_ovf      <= w_ovf_d;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_sig   <= r_slot[w_gnt_idx];
                r_out_ch    <= w_gnt_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Slot contents are only meaningful while the pending bit is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_capture[k]) begin
                r_slot[k] <= bus.ch_sig[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef EVENT_CAPTURE_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_out_ts;
    logic [TS_WIDTH-1:0] r_ts_slot [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt <= '0;
            r_out_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_load) begin
                r_out_ts <= r_ts_slot[w_gnt_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_capture[k]) begin
                r_ts_slot[k] <= r_ts_cnt;
            end
        end
    end

    assign bus.out_ts = r_out_ts;
`else
    assign bus.out_ts = {TS_WIDTH{1'b0}};
`endif

    assign bus.ch_ovf    = r_ovf;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sig   = r_out_sig;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_event_capture_arb.sv
// Directed and random stimulus for event_capture_arb, checked every cycle against
// a rule-level reference model.
module tb_event_capture_arb;
    import event_capture_arb_pkg::*;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_WIDTH = 8;
`ifdef EVENT_CAPTURE_ARB_TIMESTAMP_EN
    localparam int unsigned TS_WIDTH   = 4;
`else
    localparam int unsigned TS_WIDTH   = 16;
`endif
    localparam int unsigned SIG_W      = NUM_CH * DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    event_capture_arb_if #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .TS_WIDTH   (TS_WIDTH)
    ) bus ();

    event_capture_arb #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .TS_WIDTH   (TS_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec;
    int n_err;

    // Reference model state
    bit [NUM_CH-1:0]       m_prev;
    bit                    m_pend [NUM_CH];
    logic [DATA_WIDTH-1:0] m_slot [NUM_CH];
    int                    m_slot_ts [NUM_CH];
    bit [NUM_CH-1:0]       m_ovf;
    int                    m_ptr;
    bit                    m_ov;
    logic [DATA_WIDTH-1:0] m_osig;
    int                    m_och;
    int                    m_ots;
    int                    m_cnt;

    task automatic model_edge(input logic [NUM_CH-1:0] req, input logic [SIG_W-1:0] sig,
                              input logic [NUM_CH-1:0] clr, input logic rdy, input logic rs);
        bit any;
        bit found;
        int g;
        if (rs) begin
            m_prev = '1;
            for (int k = 0; k < NUM_CH; k++) m_pend[k] = 0;
            m_ovf = '0;
            m_ptr = 0;
            m_ov = 0;
            m_osig = '0;
            m_och = 0;
            m_ots = 0;
            m_cnt = 0;
            return;
        end
        any = 0;
        for (int k = 0; k < NUM_CH; k++) any |= m_pend[k];
        g = 0;
        found = 0;
        if ((!m_ov || rdy) && any) begin
            for (int off = 0; off < NUM_CH; off++) begin
                if (!found && m_pend[(m_ptr + off) % NUM_CH]) begin
                    found = 1;
                    g = (m_ptr + off) % NUM_CH;
                end
            end
        end
        // Output takes the slot contents as they stood before this edge.
        if (found) begin
            m_ov = 1;
            m_osig = m_slot[g];
            m_och = g;
            m_ots = m_slot_ts[g];
            m_pend[g] = 0;
            m_ptr = (g + 1) % NUM_CH;
        end else if (rdy) begin
            m_ov = 0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (clr[k]) m_ovf[k] = 0;
            if (req[k] && !m_prev[k]) begin
                if (m_pend[k]) begin
                    m_ovf[k] = 1;
                end else begin
                    m_pend[k] = 1;
                    m_slot[k] = sig[k*DATA_WIDTH +: DATA_WIDTH];
                    m_slot_ts[k] = m_cnt;
                end
            end
        end
        m_prev = req;
        m_cnt = (m_cnt + 1) % (1 << TS_WIDTH);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] req, input logic [SIG_W-1:0] sig,
                        input logic [NUM_CH-1:0] clr, input logic rdy, input logic rs);
        int exp_ts;
        rst = rs;
        bus.ch_req = req;
        bus.ch_sig = sig;
        bus.ovf_clr = clr;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(req, sig, clr, rdy, rs);
        #1;
`ifdef EVENT_CAPTURE_ARB_TIMESTAMP_EN
        exp_ts = m_ots;
`else
        exp_ts = 0;
`endif
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("ch_ovf", 64'(bus.ch_ovf), 64'(m_ovf));
        chk("out_sig", 64'(bus.out_sig), 64'(m_osig));
        chk("out_ch", 64'(bus.out_ch), 64'(m_och));
        chk("out_ts", 64'(bus.out_ts), 64'(exp_ts));
    endtask

    initial begin
        int unsigned ts_a;
        n_vec = 0;
        n_err = 0;

        // Reset state
        step('0, '0, '0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b1);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ovf", 64'(bus.ch_ovf), 64'd0);
        chk("rst_ts", 64'(bus.out_ts), 64'd0);

        // Single event on channel 2
        step('0, '0, '0, 1'b1, 1'b0);
        step(4'b0100, 32'h005A_0000, '0, 1'b1, 1'b0);
        chk("single_lat", 64'(bus.out_valid), 64'd0);
        step(4'b0100, 32'h005A_0000, '0, 1'b1, 1'b0);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_sig", 64'(bus.out_sig), 64'h5A);
        chk("single_ch", 64'(bus.out_ch), 64'd2);
        step(4'b0100, 32'h005A_0000, '0, 1'b1, 1'b0);
        chk("single_beat", 64'(bus.out_valid), 64'd0);

        // All channels together: round-robin 0,1,2,3 back-to-back
        step('0, '0, '0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0);
        step(4'b1111, 32'h1312_1110, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 32'h1312_1110, '0, 1'b1, 1'b0);
            chk("rr_valid", 64'(bus.out_valid), 64'd1);
            chk("rr_ch", 64'(bus.out_ch), 64'(i));
            chk("rr_sig", 64'(bus.out_sig), 64'(8'h10 + i));
        end
        step(4'b1111, 32'h1312_1110, '0, 1'b1, 1'b0);
        chk("rr_drain", 64'(bus.out_valid), 64'd0);

        // Backpressure and overflow on channel 1
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b0010, 32'h0000_AA00, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b0010, 32'h0000_BB00, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b0010, 32'h0000_CC00, '0, 1'b0, 1'b0);
        chk("bp_sig_held", 64'(bus.out_sig), 64'hAA);
        chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
        chk("bp_ovf_set", 64'(bus.ch_ovf[1]), 64'd1);
        step('0, '0, 4'b0010, 1'b0, 1'b0);
        chk("bp_ovf_clr", 64'(bus.ch_ovf[1]), 64'd0);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("bp_old_slot", 64'(bus.out_sig), 64'hBB);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("bp_drain", 64'(bus.out_valid), 64'd0);

        // Request held high through reset release
        step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b1);
        step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b0);
            chk("rstrel_quiet", 64'(bus.out_valid), 64'd0);
        end
        step('0, '0, '0, 1'b1, 1'b0);
        step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b0);
        step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b0);
        chk("rstrel_evt", 64'(bus.out_sig), 64'h77);
        step(4'b0001, 32'h0000_0077, '0, 1'b1, 1'b0);
        chk("rstrel_one", 64'(bus.out_valid), 64'd0);

        // Channel 3 re-event in the cycle it is granted
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b0001, 32'h0000_0001, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b1000, 32'h3100_0000, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        step(4'b1000, 32'h3200_0000, '0, 1'b1, 1'b0);
        chk("regrant_ch", 64'(bus.out_ch), 64'd3);
        chk("regrant_sig1", 64'(bus.out_sig), 64'h31);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("regrant_sig2", 64'(bus.out_sig), 64'h32);
        chk("regrant_valid2", 64'(bus.out_valid), 64'd1);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("regrant_done", 64'(bus.out_valid), 64'd0);
        chk("regrant_no_ovf", 64'(bus.ch_ovf[3]), 64'd0);

`ifdef EVENT_CAPTURE_ARB_TIMESTAMP_EN
        // Two events 20 cycles apart with a 4-bit counter
        step('0, '0, '0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0);
        step(4'b0001, 32'h0000_0001, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        ts_a = 32'(bus.out_ts);
        for (int i = 0; i < 18; i++) step('0, '0, '0, 1'b1, 1'b0);
        step(4'b0001, 32'h0000_0002, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("ts_delta", 64'((32'(bus.out_ts) - ts_a) & 32'hF), 64'd4);
`else
        ts_a = 0;
        chk("ts_zero", 64'(bus.out_ts) + 64'(ts_a), 64'd0);
`endif

        // Random traffic, including resets mid-transfer
        for (int i = 0; i < 600; i++) begin
            step(NUM_CH'($urandom), SIG_W'($urandom),
                 ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
